// File: rtl/jit_domain_switch_unit.sv
// Purpose : owns the current execution domain and a return-domain stack; runs CHDOM/RETDOM
//           as pipeline-draining transactions and answers ACCESS permission checks.
// Latency : ACCESS / rejected ops respond 1 cycle after accept; legal switches >= 3 cycles.
// Backpr. : req_ready is high only in IDLE; responses are single-cycle pulses with no backpressure.
// Ports   : clk_i/rst_i (sync active-high), flush_i; req_valid_i/req_ready_o/req_op_i/req_dom_i
//           request channel; drain_req_o/drain_done_i pipeline drain handshake; resp_* response
//           pulse; cur_dom_o/stack_depth_o state view; cfg_* matrix row write port.
module jit_domain_switch_unit #(
    parameter int NR_DOMAINS  = 4,
    parameter int DOM_W       = (NR_DOMAINS > 1) ? $clog2(NR_DOMAINS) : 1,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_DOM   = 0,
    parameter logic [NR_DOMAINS*NR_DOMAINS-1:0] CALL_PERM_RST = 'h0002,
    parameter logic [NR_DOMAINS*NR_DOMAINS-1:0] ACC_PERM_RST  = 'h0071,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [DOM_W-1:0]      req_dom_i,
    output logic                  drain_req_o,
    input  logic                  drain_done_i,
    output logic                  resp_valid_o,
    output logic                  resp_ok_o,
    output logic [1:0]            resp_cause_o,
    output logic [DOM_W-1:0]      cur_dom_o,
    output logic [DEPTH_W-1:0]    stack_depth_o,
    input  logic                  cfg_we_i,
    input  logic                  cfg_sel_i,
    input  logic [DOM_W-1:0]      cfg_row_i,
    input  logic [NR_DOMAINS-1:0] cfg_wdata_i
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] OP_ACCESS = 2'd0;
    localparam logic [1:0] OP_CHDOM  = 2'd1;
    localparam logic [1:0] OP_RETDOM = 2'd2;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_PERM  = 2'd1;
    localparam logic [1:0] CAUSE_OVF   = 2'd2;
    localparam logic [1:0] CAUSE_UNDF  = 2'd3;

    localparam logic [DOM_W:0]   NR_DOM_L    = (DOM_W+1)'(NR_DOMAINS);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [1:0]            state;
    logic [1:0]            op_q;
    logic [DOM_W-1:0]      dom_q;
    logic [DOM_W-1:0]      cur;
    logic [DEPTH_W-1:0]    depth;
    logic                  ok_q;
    logic [1:0]            cause_q;
    logic [DOM_W-1:0]      stk    [STACK_DEPTH];
    logic [NR_DOMAINS-1:0] call_m [NR_DOMAINS];
    logic [NR_DOMAINS-1:0] acc_m  [NR_DOMAINS];

    logic             accept;
    logic             dom_in_range;
    logic             call_ok;
    logic             acc_ok;
    logic             not_full;
    logic             not_empty;
    logic [PTR_W-1:0] push_ptr;
    logic [PTR_W-1:0] top_ptr;

    // A flush in IDLE holds off acceptance for that cycle only.
    assign accept       = req_valid_i && req_ready_o && !flush_i;
    // For non power-of-two domain counts the encoding can exceed the table;
    // the range test masks any out-of-bounds matrix read.
    assign dom_in_range = ({1'b0, req_dom_i} < NR_DOM_L);
    assign call_ok      = dom_in_range && call_m[cur][req_dom_i];
    assign acc_ok       = dom_in_range && acc_m[cur][req_dom_i];
    assign not_full     = (depth < DEPTH_MAX);
    assign not_empty    = (depth != '0);
    assign push_ptr     = PTR_W'(depth);
    assign top_ptr      = PTR_W'(depth - DEPTH_W'(1));

    assign req_ready_o   = (state == ST_IDLE);
    assign drain_req_o   = (state == ST_DRAIN);
    assign resp_valid_o  = (state == ST_RESP) && !flush_i;
    assign resp_ok_o     = resp_valid_o && ok_q;
    assign resp_cause_o  = resp_valid_o ? cause_q : CAUSE_NONE;
    assign cur_dom_o     = cur;
    assign stack_depth_o = depth;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            op_q    <= OP_ACCESS;
            dom_q   <= '0;
            cur     <= DOM_W'(RESET_DOM);
            depth   <= '0;
            ok_q    <= 1'b0;
            cause_q <= CAUSE_NONE;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk[i] <= '0;
            end
            for (int r = 0; r < NR_DOMAINS; r++) begin
                call_m[r] <= CALL_PERM_RST[r*NR_DOMAINS +: NR_DOMAINS];
                acc_m[r]  <= ACC_PERM_RST[r*NR_DOMAINS +: NR_DOMAINS];
            end
        end else begin
            // Matrix writes land next cycle, so a same-cycle request sees the old row.
            if (cfg_we_i) begin
                if (cfg_sel_i) begin
                    acc_m[cfg_row_i] <= cfg_wdata_i;
                end else begin
                    call_m[cfg_row_i] <= cfg_wdata_i;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q  <= req_op_i;
                        dom_q <= req_dom_i;
                        case (req_op_i)
                            OP_ACCESS: begin
                                ok_q    <= acc_ok;
                                cause_q <= acc_ok ? CAUSE_NONE : CAUSE_PERM;
                                state   <= ST_RESP;
                            end
                            OP_CHDOM: begin
                                // Permission is reported ahead of overflow.
                                if (!call_ok) begin
                                    ok_q    <= 1'b0;
                                    cause_q <= CAUSE_PERM;
                                    state   <= ST_RESP;
                                end else if (!not_full) begin
                                    ok_q    <= 1'b0;
                                    cause_q <= CAUSE_OVF;
                                    state   <= ST_RESP;
                                end else begin
                                    state   <= ST_DRAIN;
                                end
                            end
                            OP_RETDOM: begin
                                if (!not_empty) begin
                                    ok_q    <= 1'b0;
                                    cause_q <= CAUSE_UNDF;
                                    state   <= ST_RESP;
                                end else begin
                                    state   <= ST_DRAIN;
                                end
                            end
                            default: begin
                                ok_q    <= 1'b0;
                                cause_q <= CAUSE_UNDF;
                                state   <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_DRAIN: begin
                    // Flush wins over a simultaneous drain_done: the switch is abandoned silently.
                    if (flush_i) begin
                        state <= ST_IDLE;
                    end else if (drain_done_i) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (op_q == OP_CHDOM) begin
                        stk[push_ptr] <= cur;
                        cur           <= dom_q;
                        depth         <= depth + DEPTH_W'(1);
                    end else begin
                        cur           <= stk[top_ptr];
                        depth         <= depth - DEPTH_W'(1);
                    end
                    ok_q    <= 1'b1;
                    cause_q <= CAUSE_NONE;
                    state   <= ST_RESP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jit_domain_switch_unit.sv
// Purpose : directed self-checking bench for jit_domain_switch_unit (default and 2-deep stack builds).
// Latency : responses are searched for within a bounded cycle window after each request.
// Backpr. : bench only issues requests while the observed unit reports ready.
module tb_jit_domain_switch_unit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       flush = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_op = 2'd0;
    logic [1:0] req_dom = 2'd0;
    logic       drain_done = 1'b0;
    logic       cfg_we = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [1:0] cfg_row = 2'd0;
    logic [3:0] cfg_wdata = 4'd0;

    logic       a_ready, a_drain, a_rv, a_ok;
    logic [1:0] a_cause, a_cur;
    logic [2:0] a_depth;
    logic       b_ready, b_drain, b_rv, b_ok;
    logic [1:0] b_cause, b_cur;
    logic [1:0] b_depth;

    // Selects which instance the checks observe.
    logic       sel = 1'b0;
    logic       o_ready, o_drain, o_rv, o_ok;
    logic [1:0] o_cause, o_cur;
    logic [2:0] o_depth;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    jit_domain_switch_unit u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(a_ready), .req_op_i(req_op), .req_dom_i(req_dom),
        .drain_req_o(a_drain), .drain_done_i(drain_done),
        .resp_valid_o(a_rv), .resp_ok_o(a_ok), .resp_cause_o(a_cause),
        .cur_dom_o(a_cur), .stack_depth_o(a_depth),
        .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_row_i(cfg_row), .cfg_wdata_i(cfg_wdata)
    );

    jit_domain_switch_unit #(.STACK_DEPTH(2), .CALL_PERM_RST(16'hFFFF)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(b_ready), .req_op_i(req_op), .req_dom_i(req_dom),
        .drain_req_o(b_drain), .drain_done_i(drain_done),
        .resp_valid_o(b_rv), .resp_ok_o(b_ok), .resp_cause_o(b_cause),
        .cur_dom_o(b_cur), .stack_depth_o(b_depth),
        .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_row_i(cfg_row), .cfg_wdata_i(cfg_wdata)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_drain = sel ? b_drain : a_drain;
    assign o_rv    = sel ? b_rv    : a_rv;
    assign o_ok    = sel ? b_ok    : a_ok;
    assign o_cause = sel ? b_cause : a_cause;
    assign o_cur   = sel ? b_cur   : a_cur;
    assign o_depth = sel ? {1'b0, b_depth} : a_depth;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp_cur, input logic [2:0] exp_depth);
        chk({tag, ".cur"}, 32'(o_cur), 32'(exp_cur));
        chk({tag, ".depth"}, 32'(o_depth), 32'(exp_depth));
    endtask

    // Issues one request from a negedge in IDLE. drain_done is held low for nlow
    // DRAIN cycles and raised on the next one. Returns at the negedge after the
    // response cycle, i.e. back in IDLE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [1:0] dom,
                          input int nlow, input logic exp_ok, input logic [1:0] exp_cause,
                          input int exp_lat);
        int lat;
        int ndrain;
        bit got;
        chk({tag, ".ready"}, 32'(o_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_dom   = dom;
        @(negedge clk_i);
        req_valid = 1'b0;
        cfg_we    = 1'b0;
        lat    = 1;
        ndrain = 0;
        got    = 1'b0;
        while (lat < 20 && !got) begin
            if (o_rv) begin
                got = 1'b1;
            end else begin
                if (o_drain) begin
                    ndrain++;
                    drain_done = (ndrain > nlow);
                end else begin
                    drain_done = 1'b0;
                end
                @(negedge clk_i);
                lat++;
            end
        end
        drain_done = 1'b0;
        chk({tag, ".resp_seen"}, 32'(got), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".ok"}, 32'(o_ok), 32'(exp_ok));
        chk({tag, ".cause"}, 32'(o_cause), 32'(exp_cause));
        chk({tag, ".drain_cycles"}, 32'(ndrain), (exp_lat == 1) ? 32'd0 : 32'(nlow + 1));
        @(negedge clk_i);
    endtask

    initial begin
        // ---------------- default build ----------------
        sel = 1'b0;
        do_reset();
        chk("rst.ready", 32'(o_ready), 32'd1);
        chk("rst.resp_valid", 32'(o_rv), 32'd0);
        chk("rst.ok", 32'(o_ok), 32'd0);
        chk("rst.cause", 32'(o_cause), 32'd0);
        chk("rst.drain_req", 32'(o_drain), 32'd0);
        chk_state("rst", 2'd0, 3'd0);

        run_op("acc_d0_0", 2'd0, 2'd0, 0, 1'b1, 2'd0, 1);
        chk_state("acc_d0_0", 2'd0, 3'd0);
        run_op("acc_d0_2", 2'd0, 2'd2, 0, 1'b0, 2'd1, 1);

        // CHDOM 0->1 with drain_done on the 3rd DRAIN cycle: 3 drain cycles, resp 2 after exit.
        run_op("chdom_0_1", 2'd1, 2'd1, 2, 1'b1, 2'd0, 5);
        chk_state("chdom_0_1", 2'd1, 3'd1);
        run_op("acc_d1_2", 2'd0, 2'd2, 0, 1'b1, 2'd0, 1);
        run_op("acc_d1_3", 2'd0, 2'd3, 0, 1'b0, 2'd1, 1);

        run_op("chdom_1_0", 2'd1, 2'd0, 0, 1'b0, 2'd1, 1);
        chk_state("chdom_1_0", 2'd1, 3'd1);
        run_op("ret_1", 2'd2, 2'd3, 0, 1'b1, 2'd0, 3);
        chk_state("ret_1", 2'd0, 3'd0);
        run_op("ret_empty", 2'd2, 2'd0, 0, 1'b0, 2'd3, 1);
        chk_state("ret_empty", 2'd0, 3'd0);
        run_op("reserved", 2'd3, 2'd1, 0, 1'b0, 2'd3, 1);
        chk_state("reserved", 2'd0, 3'd0);

        // Flush during the 2nd DRAIN cycle aborts the switch silently.
        chk("flush_drain.ready", 32'(o_ready), 32'd1);
        req_valid = 1'b1; req_op = 2'd1; req_dom = 2'd1;
        @(negedge clk_i);
        req_valid = 1'b0;
        chk("flush_drain.drain1", 32'(o_drain), 32'd1);
        @(negedge clk_i);
        chk("flush_drain.drain2", 32'(o_drain), 32'd1);
        flush = 1'b1;
        @(negedge clk_i);
        flush = 1'b0;
        chk("flush_drain.resp_valid", 32'(o_rv), 32'd0);
        chk("flush_drain.drain_after", 32'(o_drain), 32'd0);
        chk("flush_drain.ready_after", 32'(o_ready), 32'd1);
        chk_state("flush_drain", 2'd0, 3'd0);
        @(negedge clk_i);
        chk("flush_drain.no_late_resp", 32'(o_rv), 32'd0);

        // Same-cycle matrix write does not affect the request it coincides with.
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_row = 2'd0; cfg_wdata = 4'b0100;
        run_op("cfg_same", 2'd1, 2'd2, 0, 1'b0, 2'd1, 1);
        chk_state("cfg_same", 2'd0, 3'd0);
        run_op("cfg_next", 2'd1, 2'd2, 0, 1'b1, 2'd0, 3);
        chk_state("cfg_next", 2'd2, 3'd1);

        // Flush in the response cycle suppresses the pulse.
        req_valid = 1'b1; req_op = 2'd0; req_dom = 2'd0;
        @(negedge clk_i);
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("flush_resp.resp_valid", 32'(o_rv), 32'd0);
        @(negedge clk_i);
        flush = 1'b0;
        chk("flush_resp.ready", 32'(o_ready), 32'd1);

        // Reset mid-transaction: back to reset values with no response.
        req_valid = 1'b1; req_op = 2'd2; req_dom = 2'd0;
        @(negedge clk_i);
        req_valid = 1'b0;
        chk("rst_mid.in_drain", 32'(o_drain), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_mid.resp_valid", 32'(o_rv), 32'd0);
        chk("rst_mid.drain", 32'(o_drain), 32'd0);
        chk_state("rst_mid", 2'd0, 3'd0);

        // ---------------- 2-deep stack, all calls permitted ----------------
        sel = 1'b1;
        do_reset();
        chk_state("s2.rst", 2'd0, 3'd0);
        run_op("s2.ch_0_1", 2'd1, 2'd1, 0, 1'b1, 2'd0, 3);
        run_op("s2.ch_1_2", 2'd1, 2'd2, 1, 1'b1, 2'd0, 4);
        chk_state("s2.two", 2'd2, 3'd2);
        run_op("s2.ch_2_3", 2'd1, 2'd3, 0, 1'b0, 2'd2, 1);
        chk_state("s2.ovf", 2'd2, 3'd2);
        run_op("s2.ret", 2'd2, 2'd0, 0, 1'b1, 2'd0, 3);
        chk_state("s2.ret", 2'd1, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
